apb4_mem_slave: RTL

APB4 memory-mapped slave, successor to the single-cycle APB register-file slave. Adds byte-lane write strobes, programmable wait states, data-width-derived alignment checking, optional privileged-write protection, and a saturating error counter. Sits behind the AHB-to-APB bridge on the APB segment as a generic SRAM-backed peripheral window.

---
 rtl/apb4_mem_slave.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/apb4_mem_slave.sv
// apb4_mem_slave -- APB4 SRAM-backed peripheral window.
//
// A transfer's setup-phase signals are captured in IDLE. The slave then spends
// WAIT_STATES cycles in WAIT and answers for one cycle in RESP. The memory
// write and the error-count update take effect on the RESP edge, and only when
// the master still holds PSEL & PENABLE there. Read data is fetched on the
// edge that enters RESP.
//
// Ports:
//   PCLK, PRESET          clock; asynchronous active-high reset
//   PSEL, PENABLE, PWRITE APB control
//   PADDR[31:0]           byte address; the tag bits above the word index must
//                         equal BASE_ADDR
//   PWDATA, PSTRB         write data and byte-lane enables
//   PPROT[2:0]            bit 0 = privileged; the other bits are ignored
//   PRDATA                registered read data, held outside RESP
//   PREADY, PSLVERR       registered response (PSLVERR only with PREADY)
//   err_count[7:0]        saturating count of committed errored transfers
module apb4_mem_slave #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          DATA_WIDTH  = 32,
  // Only the low 32-ALIGN-ADDR_WIDTH bits are significant.
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          WAIT_STATES = 0,
  parameter bit          PRIV_WRITE  = 1'b0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [31:0]             PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [7:0]              err_count
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int ALIGN  = $clog2(NBYTES);
  localparam int TAG_LO = ALIGN + ADDR_WIDTH;
  localparam int TAGW   = 32 - TAG_LO;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    wr_q, err_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NBYTES-1:0]       strb_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Decode of the live bus. It is used at setup, and for the read when there
  // are no wait states, because then RESP follows IDLE directly.
  logic                  setup, err_in;
  logic [ADDR_WIDTH-1:0] idx_in;
  assign setup  = PSEL & ~PENABLE;
  assign idx_in = PADDR[TAG_LO-1:ALIGN];
  assign err_in = (PADDR[31:TAG_LO] != BASE_ADDR[TAGW-1:0])
                | (PADDR[ALIGN-1:0] != '0)
                | (PRIV_WRITE & PWRITE & ~PPROT[0]);

  logic unused_prot;
  assign unused_prot = ^PPROT[2:1];

  // ---- state register ----
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) state <= S_IDLE;
    else        state <= state_nxt;

  // ---- next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (setup) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (!PSEL) state_nxt = S_IDLE;       // master abandoned transfer
              else if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- control outputs ----
  logic                  latch_en, enter_resp, commit, mem_we, err_inc;
  logic                  rd_err, rd_wr;
  logic [ADDR_WIDTH-1:0] rd_idx;
  always_comb begin
    latch_en   = (state == S_IDLE) && setup;
    enter_resp = (state != S_RESP) && (state_nxt == S_RESP);
    commit     = (state == S_RESP) && PSEL && PENABLE;
    mem_we     = commit && wr_q && !err_q;
    err_inc    = commit && err_q;
    // Entering RESP from IDLE means no wait states. The latches are not yet
    // loaded in that case, so the live decode is used.
    rd_idx     = (state == S_IDLE) ? idx_in : idx_q;
    rd_err     = (state == S_IDLE) ? err_in : err_q;
    rd_wr      = (state == S_IDLE) ? PWRITE : wr_q;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt       <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      err_count <= '0;
    end else begin
      if (latch_en) begin
        cnt     <= WS4;
        idx_q   <= idx_in;
        wr_q    <= PWRITE;
        err_q   <= err_in;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
      end else if (state == S_WAIT && PSEL) begin
        cnt <= cnt - 4'd1;
      end
      PREADY  <= enter_resp;
      PSLVERR <= enter_resp && rd_err;
      if (enter_resp && !rd_wr)
        PRDATA <= rd_err ? '0 : mem[rd_idx];
      if (err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // Storage is deliberately not reset. A reset aborts the FSM, so mem_we
  // cannot fire for a transfer that was pending when reset arrived.
  always_ff @(posedge PCLK)
    for (int i = 0; i < NBYTES; i++)
      if (mem_we && strb_q[i])
        mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];

endmodule
